// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: Moore FSM sequencing shared ALU, unified memory and register file.
// Outputs decode state (plus Zero/MemReady); request states stall until MemReady.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IllegalOp,
  output logic       InstrDone
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  state_t     r_state;
  state_t     w_next;
  logic       w_funct_ok;
  logic [2:0] w_funct_alu;
  logic       w_memreq;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_illegal;
  logic       w_done;

  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = 3'b000;
    case (Funct)
      6'b100000: w_funct_alu = 3'b010;
      6'b100010: w_funct_alu = 3'b110;
      6'b100100: w_funct_alu = 3'b000;
      6'b100101: w_funct_alu = 3'b001;
      6'b101010: w_funct_alu = 3'b111;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_memreq   = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    w_done     = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    PCSrc      = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_memreq   = 1'b1;
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        w_irwrite  = MemReady;
        w_pcwrite  = MemReady;
        if (MemReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        ALUControl = ALU_ADD;
        case (Op)
          6'b100011, 6'b101011: w_next = S_MEMADR;
          6'b000000: begin
            w_next    = w_funct_ok ? S_EXECUTE : S_FETCH;
            w_illegal = ~w_funct_ok;
          end
          6'b000100: w_next = S_BRANCH;
          6'b001000: w_next = S_ADDIEX;
          6'b000010: w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        if (r_state == S_ADDIEX)   w_next = S_ADDIWB;
        else if (Op == 6'b100011)  w_next = S_MEMREAD;
        else                       w_next = S_MEMWR;
      end
      S_MEMREAD: begin
        w_memreq = 1'b1;
        IorD     = 1'b1;
        if (MemReady) w_next = S_MEMWB;
      end
      S_MEMWR: begin
        w_memreq   = 1'b1;
        IorD       = 1'b1;
        w_memwrite = 1'b1;
        w_done     = MemReady;
        if (MemReady) w_next = S_FETCH;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = w_funct_alu;
        w_next     = S_ALUWB;
      end
      S_ALUWB, S_ADDIWB: begin
        RegDst     = (r_state == S_ALUWB);
        w_regwrite = 1'b1;
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        w_branch   = 1'b1;
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_done    = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset masks every enable/pulse so an aborted instruction writes nothing.
  assign MemReq    = w_memreq   & ~reset;
  assign MemWrite  = w_memwrite & ~reset;
  assign IRWrite   = w_irwrite  & ~reset;
  assign RegWrite  = w_regwrite & ~reset;
  assign PCEn      = (w_pcwrite | (w_branch & Zero)) & ~reset;
  assign IllegalOp = w_illegal  & ~reset;
  assign InstrDone = w_done     & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven checks of the multicycle controller output vector per cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       Zero, MemReady;
  logic       MemReq, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn, IllegalOp, InstrDone;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .IllegalOp(IllegalOp),
    .InstrDone(InstrDone)
  );

  always #5 clk = ~clk;

  // Packed order: MemReq IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
  //               ALUSrcB[2] ALUControl[3] PCSrc[2] PCEn IllegalOp InstrDone
  localparam logic [18:0] O_FETCH_RDY  = 19'b1_0_0_1_0_0_0_0_01_010_00_1_0_0;
  localparam logic [18:0] O_FETCH_WAIT = 19'b1_0_0_0_0_0_0_0_01_010_00_0_0_0;
  localparam logic [18:0] O_RST_FETCH  = 19'b0_0_0_0_0_0_0_0_01_010_00_0_0_0;
  localparam logic [18:0] O_DECODE     = 19'b0_0_0_0_0_0_0_0_11_010_00_0_0_0;
  localparam logic [18:0] O_DECODE_ILL = 19'b0_0_0_0_0_0_0_0_11_010_00_0_1_0;
  localparam logic [18:0] O_MEMADR     = 19'b0_0_0_0_0_0_0_1_10_010_00_0_0_0;
  localparam logic [18:0] O_MEMREAD    = 19'b1_1_0_0_0_0_0_0_00_000_00_0_0_0;
  localparam logic [18:0] O_MEMWB      = 19'b0_0_0_0_0_1_1_0_00_000_00_0_0_1;
  localparam logic [18:0] O_MEMWR_WAIT = 19'b1_1_1_0_0_0_0_0_00_000_00_0_0_0;
  localparam logic [18:0] O_MEMWR_RDY  = 19'b1_1_1_0_0_0_0_0_00_000_00_0_0_1;
  localparam logic [18:0] O_RST_MEMWR  = 19'b0_1_0_0_0_0_0_0_00_000_00_0_0_0;
  localparam logic [18:0] O_EX_ADD     = 19'b0_0_0_0_0_0_0_1_00_010_00_0_0_0;
  localparam logic [18:0] O_EX_SUB     = 19'b0_0_0_0_0_0_0_1_00_110_00_0_0_0;
  localparam logic [18:0] O_EX_AND     = 19'b0_0_0_0_0_0_0_1_00_000_00_0_0_0;
  localparam logic [18:0] O_EX_OR      = 19'b0_0_0_0_0_0_0_1_00_001_00_0_0_0;
  localparam logic [18:0] O_EX_SLT     = 19'b0_0_0_0_0_0_0_1_00_111_00_0_0_0;
  localparam logic [18:0] O_ALUWB      = 19'b0_0_0_0_1_0_1_0_00_000_00_0_0_1;
  localparam logic [18:0] O_ADDIWB     = 19'b0_0_0_0_0_0_1_0_00_000_00_0_0_1;
  localparam logic [18:0] O_BR_TAKEN   = 19'b0_0_0_0_0_0_0_1_00_110_01_1_0_1;
  localparam logic [18:0] O_BR_NOT     = 19'b0_0_0_0_0_0_0_1_00_110_01_0_0_1;
  localparam logic [18:0] O_JUMP       = 19'b0_0_0_0_0_0_0_0_00_000_10_1_0_1;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mr;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [18:0] outs();
    return {MemReq, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, ALUControl, PCSrc, PCEn, IllegalOp, InstrDone};
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic m, input logic [18:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.mr = m; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs after the falling edge, compare before the rising edge.
  task automatic step(input string name, input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic m, input logic [18:0] e);
    logic [18:0] got;
    @(negedge clk);
    reset = r; Op = o; Funct = f; Zero = z; MemReady = m;
    #2;
    got = outs();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: outputs got %b expected %b", name, got, e);
    end
  endtask

  initial begin
    reset = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; MemReady = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 3; i++) add(1, OP_R, F_ADD, 0, 1, O_RST_FETCH);
    // add
    add(0, OP_R, F_ADD, 0, 1, O_FETCH_RDY);
    add(0, OP_R, F_ADD, 0, 0, O_DECODE);
    add(0, OP_R, F_ADD, 0, 1, O_EX_ADD);
    add(0, OP_R, F_ADD, 0, 0, O_ALUWB);
    // sub, and, or, slt
    add(0, OP_R, F_SUB, 0, 1, O_FETCH_RDY); add(0, OP_R, F_SUB, 0, 1, O_DECODE);
    add(0, OP_R, F_SUB, 0, 1, O_EX_SUB);    add(0, OP_R, F_SUB, 0, 1, O_ALUWB);
    add(0, OP_R, F_AND, 0, 1, O_FETCH_RDY); add(0, OP_R, F_AND, 0, 1, O_DECODE);
    add(0, OP_R, F_AND, 1, 1, O_EX_AND);    add(0, OP_R, F_AND, 0, 1, O_ALUWB);
    add(0, OP_R, F_OR, 0, 1, O_FETCH_RDY);  add(0, OP_R, F_OR, 0, 1, O_DECODE);
    add(0, OP_R, F_OR, 0, 1, O_EX_OR);      add(0, OP_R, F_OR, 0, 1, O_ALUWB);
    add(0, OP_R, F_SLT, 0, 1, O_FETCH_RDY); add(0, OP_R, F_SLT, 0, 1, O_DECODE);
    add(0, OP_R, F_SLT, 0, 1, O_EX_SLT);    add(0, OP_R, F_SLT, 0, 1, O_ALUWB);
    // lw with two stalled MemRead cycles
    add(0, OP_LW, 6'd0, 0, 1, O_FETCH_RDY); add(0, OP_LW, 6'd0, 0, 1, O_DECODE);
    add(0, OP_LW, 6'd0, 0, 0, O_MEMADR);    add(0, OP_LW, 6'd0, 0, 0, O_MEMREAD);
    add(0, OP_LW, 6'd0, 0, 0, O_MEMREAD);   add(0, OP_LW, 6'd0, 0, 1, O_MEMREAD);
    add(0, OP_LW, 6'd0, 0, 0, O_MEMWB);
    // sw after one stalled fetch, one stalled MemWr cycle
    add(0, OP_SW, 6'd0, 0, 0, O_FETCH_WAIT); add(0, OP_SW, 6'd0, 0, 1, O_FETCH_RDY);
    add(0, OP_SW, 6'd0, 0, 1, O_DECODE);     add(0, OP_SW, 6'd0, 0, 1, O_MEMADR);
    add(0, OP_SW, 6'd0, 0, 0, O_MEMWR_WAIT); add(0, OP_SW, 6'd0, 0, 1, O_MEMWR_RDY);
    // beq taken then not taken
    add(0, OP_BEQ, 6'd0, 0, 1, O_FETCH_RDY); add(0, OP_BEQ, 6'd0, 0, 1, O_DECODE);
    add(0, OP_BEQ, 6'd0, 1, 1, O_BR_TAKEN);
    add(0, OP_BEQ, 6'd0, 0, 1, O_FETCH_RDY); add(0, OP_BEQ, 6'd0, 0, 1, O_DECODE);
    add(0, OP_BEQ, 6'd0, 0, 1, O_BR_NOT);
    // addi, j
    add(0, OP_ADDI, 6'd0, 0, 1, O_FETCH_RDY); add(0, OP_ADDI, 6'd0, 0, 1, O_DECODE);
    add(0, OP_ADDI, 6'd0, 0, 1, O_MEMADR);    add(0, OP_ADDI, 6'd0, 0, 1, O_ADDIWB);
    add(0, OP_J, 6'd0, 0, 1, O_FETCH_RDY);    add(0, OP_J, 6'd0, 0, 1, O_DECODE);
    add(0, OP_J, 6'd0, 0, 1, O_JUMP);
    // illegal opcode, then illegal R-type funct
    add(0, 6'b111111, 6'd0, 1, 1, O_FETCH_RDY); add(0, 6'b111111, 6'd0, 1, 1, O_DECODE_ILL);
    add(0, OP_R, 6'd0, 1, 1, O_FETCH_RDY);      add(0, OP_R, 6'd0, 1, 1, O_DECODE_ILL);
    add(0, OP_R, 6'd0, 1, 0, O_FETCH_WAIT);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].funct,
           vecs[i].zero, vecs[i].mr, vecs[i].exp);

    // Reset during a stalled sw store aborts it; no MemWrite afterwards.
    step("sw_rst_fetch",  0, OP_SW, 6'd0, 0, 1, O_FETCH_RDY);
    step("sw_rst_decode", 0, OP_SW, 6'd0, 0, 1, O_DECODE);
    step("sw_rst_memadr", 0, OP_SW, 6'd0, 0, 1, O_MEMADR);
    step("sw_rst_memwr",  0, OP_SW, 6'd0, 0, 0, O_MEMWR_WAIT);
    step("sw_rst_abort",  1, OP_SW, 6'd0, 0, 0, O_RST_MEMWR);
    step("sw_rst_after",  0, OP_SW, 6'd0, 0, 0, O_FETCH_WAIT);

    // Reset and MemReady on the same edge in Fetch: reset wins, stays in Fetch.
    step("rst_vs_rdy",       1, OP_R, F_ADD, 0, 1, O_RST_FETCH);
    step("rst_vs_rdy_after", 0, OP_R, F_ADD, 0, 0, O_FETCH_WAIT);
    step("rst_vs_rdy_fetch", 0, OP_R, F_ADD, 0, 1, O_FETCH_RDY);
    step("rst_vs_rdy_dec",   0, OP_R, F_ADD, 0, 1, O_DECODE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS controller: a Moore FSM that sequences one shared ALU, one unified instruction/data memory and the register file over several cycles per instruction. It replaces the purely combinational single-cycle decode for the multicycle datapath. It drives every mux select and write enable each cycle, and it stalls on a simple memory request/ready handshake. It decodes lw, sw, R-type (add, sub, and, or, slt), beq, addi and j.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset sampled on rising edge of clk
- Op  in  6  instruction[31:26] from the instruction register
- Funct  in  6  instruction[5:0] from the instruction register
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- MemReq  out  1  memory access requested (Fetch, MemRead, MemWrite states)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register load
- RegDst  out  1  register write address: 0 = rt, 1 = rd
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = Data register
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B operand: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- ALUControl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load enable; equals PCWrite | (Branch & Zero)
- IllegalOp  out  1  one-cycle pulse in Decode when the instruction is unsupported
- InstrDone  out  1  one-cycle pulse on the last cycle of each completed instruction

## Operation
- State is a 4-bit register with 12 states:
  - Fetch (0), Decode (1), MemAdr (2), MemRead (3), MemWB (4), MemWr (5)
  - Execute (6), AluWB (7), Branch (8), AddiEx (9), AddiWB (10), Jump (11)
- Outputs are a combinational decode of state, plus Zero and MemReady where noted.
- Any output not listed for a state is 0. No x values are driven.
- Per-state outputs:
  - Fetch: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00. IRWrite and PCWrite are asserted only while MemReady=1.
  - Decode: ALUSrcA=0, ALUSrcB=11, add. This computes the branch target into ALUOut.
  - MemAdr and AddiEx: ALUSrcA=1, ALUSrcB=10, add.
  - MemRead: MemReq=1, IorD=1.
  - MemWr: MemReq=1, IorD=1, MemWrite=1. MemWrite is held for the whole state.
  - MemWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - Execute: ALUSrcA=1, ALUSrcB=00. ALUControl comes from Funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - AluWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - AddiWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - Branch: ALUSrcA=1, ALUSrcB=00, sub (110), PCSrc=01, Branch=1.
  - Jump: PCSrc=10, PCWrite=1.
- Transitions:
  - Fetch→Decode on MemReady; otherwise Fetch holds.
  - Decode dispatches on Op:
    - 100011 or 101011 → MemAdr
    - 000000 with a supported Funct → Execute
    - 000100 → Branch
    - 001000 → AddiEx
    - 000010 → Jump
    - anything else → Fetch with IllegalOp=1
  - MemAdr→MemRead for lw, MemAdr→MemWr for sw.
  - MemRead→MemWB on MemReady; otherwise holds.
  - MemWr→Fetch on MemReady; otherwise holds.
  - Execute→AluWB, AddiEx→AddiWB.
  - MemWB, AluWB, AddiWB, Branch and Jump → Fetch.
- InstrDone=1 on these cycles:
  - MemWB, AluWB, AddiWB, Branch, Jump
  - MemWr while MemReady=1
- An unsupported R-type Funct is treated as an illegal op: IllegalOp=1, return to Fetch, no register, memory or PC write.

## Timing
- Reset is synchronous. With reset=1 at a rising edge, state becomes Fetch.
- While reset=1, these outputs are forced to 0 regardless of state: MemReq, MemWrite, IRWrite, RegWrite, PCEn, IllegalOp, InstrDone.
- The first cycle after reset deasserts is Fetch with MemReq=1.
- Reset asserted mid-instruction aborts it. No further write enable is asserted after that edge.
- Op and Funct must be stable from Decode through the end of the instruction; IR loads only in Fetch.
- Zero is sampled combinationally in Branch. PCEn=1 in Branch only when Zero=1.
- Minimum latency in cycles, with MemReady=1 on the first request cycle: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle MemReady is low in a request state adds exactly one cycle.
- MemReady is ignored outside Fetch, MemRead and MemWr.
- MemReady=1 on the same edge as reset=1: reset wins and state becomes Fetch.

## Test plan
- Reset held 3 cycles with MemReady=1 → no write enables; first post-reset cycle is Fetch with MemReq=1, IorD=0, ALUSrcB=01.
- add (Op=000000, Funct=100000), MemReady always 1 → states 0,1,6,7,0. ALUControl=010 in Execute. RegWrite=1 and RegDst=1 in AluWB. InstrDone on cycle 4.
- lw with MemReady low for 2 cycles in MemRead → states 0,1,2,3,3,3,4,0. MemReq=1 and IorD=1 for all three MemRead cycles. MemtoReg=1 in MemWB.
- beq in two passes:
  - Zero=1 → PCEn=1 and PCSrc=01 in Branch.
  - Zero=0 → PCEn=0.
  - Both take 3 cycles.
- Op=111111 → IllegalOp=1 in Decode, next state Fetch, no RegWrite, MemWrite or PCEn. Repeat with Op=000000, Funct=000000 for the same result.
- sw with reset asserted during MemWr while MemReady=0 → next state Fetch; MemWrite is 0 from that edge on.
